ram_sized_ws: RTL and testbench
===============================

RAM_SIZED_WS -- requirements
Module: ram_sized_ws

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 512: byte capacity, multiple of 4.
REQ-002 SHALL have parameter ADDR_W, default 9: byte-address width, with 2**ADDR_W >= DEPTH_BYTES.
REQ-003 SHALL have parameter WAIT_STATES, default 1: extra access cycles, range 0..15.
REQ-004 SHALL have parameter BIG_ENDIAN, default 1: 1 = byte at address A is the MSB of a word/halfword at A; 0 = LSB.
REQ-005 SHALL have port Clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port Reset, input, 1 bit: asynchronous, active-high.
REQ-007 SHALL have port MFA, input, 1 bit: memory-function-activate request.
REQ-008 SHALL have port ReadWrite, input, 1 bit: 1 = read, 0 = write.
REQ-009 SHALL have port Size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 SHALL have port Address, input, ADDR_W bits: byte address.
REQ-011 SHALL have port DataIn, input, 32 bits: write data, right-justified for byte/halfword.
REQ-012 SHALL have port DataOut, output, 32 bits: read data, zero-extended, right-justified.
REQ-013 SHALL have port MOC, output, 1 bit: memory-operation-complete.
REQ-014 SHALL have port Busy, output, 1 bit: high in any state except IDLE.
REQ-015 SHALL have port Error, output, 1 bit: access rejected; valid while MOC=1.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-017 IDLE: on an edge with MFA=1, SHALL latch ReadWrite, Size, Address, DataIn and go to WAIT if WAIT_STATES>0, else to DONE.
REQ-018 WAIT: SHALL count WAIT_STATES cycles, then go to DONE; inputs are ignored during WAIT.
REQ-019 The access (memory write or DataOut update) SHALL occur on the edge entering DONE; MOC SHALL rise on that same edge, i.e. WAIT_STATES+1 cycles after MFA is sampled.
REQ-020 DONE: MOC=1 while MFA=1; on the first edge with MFA=0, MOC SHALL go 0 and the state SHALL return to IDLE.
REQ-021 If MFA falls before DONE is reached, the accepted operation SHALL still complete, with MOC high for exactly one cycle.
REQ-022 A new request SHALL be accepted only from IDLE; MFA held high across DONE SHALL NOT start a second access.
REQ-023 Reads SHALL place the byte in DataOut[7:0] or the halfword in DataOut[15:0], with the upper bits 0; word reads SHALL fill all 32 bits.
REQ-024 Writes SHALL modify only the addressed 1/2/4 bytes, taken from DataIn[7:0]/[15:0]/[31:0].
REQ-025 Byte order within halfwords and words SHALL follow BIG_ENDIAN.
REQ-026 An access SHALL be an error if Size=11, if halfword Address[0]!=0, if word Address[1:0]!=0, or if Address+bytes > DEPTH_BYTES.
REQ-027 On error: memory unchanged, DataOut unchanged, Error=1 together with MOC, same timing as REQ-019/020.
REQ-028 Error SHALL be 0 whenever MOC=0.
REQ-029 DataOut SHALL hold its last read value through writes and idle periods.

Reset
REQ-030 Reset=1 SHALL immediately force state IDLE, MOC=0, Busy=0, Error=0, DataOut=0, wait counter=0.
REQ-031 Memory contents SHALL NOT be cleared by Reset.
REQ-032 Reset during WAIT SHALL abort the operation with no memory write; Reset in DONE SHALL leave an already-committed write intact.
REQ-033 After Reset is released, the first MFA=1 edge SHALL be treated as a new request.

Verification (WAIT_STATES=2, BIG_ENDIAN=1, defaults otherwise)
REQ-034 Write word 0xDEADBEEF at 0x010 -> MOC rises 3 cycles after MFA is sampled, Error=0; MOC falls the edge after MFA drops.
REQ-035 Read byte 0x010 -> DataOut=0x000000DE; read halfword 0x012 -> 0x0000BEEF; read byte 0x013 -> 0x000000EF.
REQ-036 Write halfword 0x1234 at 0x010, then read word 0x010 -> 0x1234BEEF.
REQ-037 Word access at 0x011, word access at 0x1FE, or Size=11 -> MOC with Error=1; memory and DataOut unchanged.
REQ-038 Write to 0x020 with Reset pulsed during WAIT -> MOC stays 0; a later word read of 0x020 returns the prior contents.
REQ-039 MFA held high for 10 cycles -> exactly one access, MOC high from cycle 3 until MFA falls; with MFA as a 1-cycle pulse -> MOC high for exactly 1 cycle.

Source files
------------

// File: rtl/ram_sized_ws.sv
// Byte-addressable RAM with byte/halfword/word accesses, selectable endianness and a MFA/MOC handshake.
// Latency: MOC rises WAIT_STATES+1 edges after a request is accepted, or on the accepting edge when WAIT_STATES=0.
// Backpressure: a request is taken only in IDLE; MOC stays high while MFA is held; new MFA is ignored until IDLE is reached.
module ram_sized_ws #(
    parameter int DEPTH_BYTES = 512,
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 1,
    parameter int BIG_ENDIAN  = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MFA,
    input  logic              ReadWrite,
    input  logic [1:0]        Size,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MOC,
    output logic              Busy,
    output logic              Error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    // Storage is deliberately never reset.
    logic [7:0] mem [0:DEPTH_BYTES-1];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rw_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;
    logic              latch;
    logic              commit;

    // Operation fields: live inputs while IDLE (needed when WAIT_STATES=0), latched copy afterwards.
    logic              op_rw;
    logic [1:0]        op_size;
    logic [ADDR_W-1:0] op_addr;
    logic [31:0]       op_din;
    logic [2:0]        nbytes;
    logic [31:0]       end_addr;
    logic              op_err;

    logic [ADDR_W-1:0] lane_addr [4];
    logic [7:0]        rd_lane   [4];
    logic [7:0]        wr_lane   [4];
    logic [3:0]        wr_en;
    logic              wr_go;
    logic [31:0]       rdata;

    assign op_rw   = (state_q == IDLE) ? ReadWrite : rw_q;
    assign op_size = (state_q == IDLE) ? Size      : size_q;
    assign op_addr = (state_q == IDLE) ? Address   : addr_q;
    assign op_din  = (state_q == IDLE) ? DataIn    : din_q;

    // Access legality: size code, natural alignment and upper bound of the touched bytes.
    always_comb begin
        nbytes = 3'd0;
        case (op_size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            2'b10:   nbytes = 3'd4;
            default: nbytes = 3'd0;
        endcase
        end_addr = {{(32-ADDR_W){1'b0}}, op_addr} + {29'd0, nbytes};
        op_err = (op_size == 2'b11)
              || ((op_size == 2'b01) && op_addr[0])
              || ((op_size == 2'b10) && (op_addr[1:0] != 2'b00))
              || (end_addr > $unsigned(DEPTH_BYTES));
    end

    // Byte lane i is the byte at address op_addr+i.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = op_addr + ADDR_W'(i);
            rd_lane[i]   = mem[lane_addr[i]];
        end
    end

    // Read data assembly, right-justified and zero-extended.
    always_comb begin
        rdata = 32'd0;
        case (op_size)
            2'b00: rdata = {24'd0, rd_lane[0]};
            2'b01: rdata = (BIG_ENDIAN != 0) ? {16'd0, rd_lane[0], rd_lane[1]}
                                             : {16'd0, rd_lane[1], rd_lane[0]};
            default: rdata = (BIG_ENDIAN != 0) ? {rd_lane[0], rd_lane[1], rd_lane[2], rd_lane[3]}
                                               : {rd_lane[3], rd_lane[2], rd_lane[1], rd_lane[0]};
        endcase
    end

    // Write lane enables and data steering from the right-justified write data.
    always_comb begin
        wr_en = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            wr_lane[i] = 8'd0;
        end
        case (op_size)
            2'b00: begin
                wr_en      = 4'b0001;
                wr_lane[0] = op_din[7:0];
            end
            2'b01: begin
                wr_en      = 4'b0011;
                wr_lane[0] = (BIG_ENDIAN != 0) ? op_din[15:8] : op_din[7:0];
                wr_lane[1] = (BIG_ENDIAN != 0) ? op_din[7:0]  : op_din[15:8];
            end
            2'b10: begin
                wr_en = 4'b1111;
                for (int i = 0; i < 4; i++) begin
                    wr_lane[i] = (BIG_ENDIAN != 0) ? op_din[8*(3-i) +: 8] : op_din[8*i +: 8];
                end
            end
            default: wr_en = 4'b0000;
        endcase
    end

    // Next-state logic: accept in IDLE, count wait cycles, hold DONE until MFA drops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (MFA) begin
                    latch = 1'b1;
                    cnt_d = 4'd0;
                    if (WS_CNT == 4'd0) begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == WS_CNT) begin
                    state_d = DONE;
                    commit  = 1'b1;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (!MFA) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A reset edge must never commit a pending write.
    assign wr_go = commit && !op_rw && !op_err && !Reset;

    // State, request latch and read-data register; reset aborts any operation in flight.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            din_q   <= 32'd0;
            DataOut <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                rw_q   <= ReadWrite;
                size_q <= Size;
                addr_q <= Address;
                din_q  <= DataIn;
            end
            if (commit && op_rw && !op_err) begin
                DataOut <= rdata;
            end
        end
    end

    // Memory write port, one enable per byte lane.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_go && wr_en[i]) begin
                mem[lane_addr[i]] <= wr_lane[i];
            end
        end
    end

    assign MOC   = (state_q == DONE);
    assign Busy  = (state_q != IDLE);
    assign Error = (state_q == DONE) && op_err;

endmodule

// File: tb/tb_ram_sized_ws.sv
// Directed bench for ram_sized_ws (WAIT_STATES=2, big-endian, 512 bytes).
// Stimulus pushes expected {Error, DataOut} per access; a monitor pops on each MOC rising edge.
// Handshake timing, reset behaviour and MFA hold/pulse cases are checked inline by the driver.
module tb_ram_sized_ws;

    logic        clk = 1'b0;
    logic        rst;
    logic        mfa;
    logic        rw;
    logic [1:0]  size;
    logic [8:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        moc;
    logic        busy;
    logic        err;

    typedef struct {
        logic        err;
        logic [31:0] dout;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    logic moc_prev   = 1'b0;

    ram_sized_ws #(
        .DEPTH_BYTES(512),
        .ADDR_W     (9),
        .WAIT_STATES(2),
        .BIG_ENDIAN (1)
    ) dut (
        .Clk      (clk),
        .Reset    (rst),
        .MFA      (mfa),
        .ReadWrite(rw),
        .Size     (size),
        .Address  (addr),
        .DataIn   (din),
        .DataOut  (dout),
        .MOC      (moc),
        .Busy     (busy),
        .Error    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, req);
        end
    endtask

    // Monitor: every MOC rising edge must match the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        if (moc && !moc_prev) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_moc: got MOC rise, want none (Error=%0b DataOut=0x%08h)", err, dout);
            end else begin
                e = sb.pop_front();
                check("moc_error", {31'd0, err}, {31'd0, e.err});
                check("moc_dataout", dout, e.dout);
            end
        end
        if (!moc && err) begin
            compared++;
            mismatched++;
            $display("FAIL error_without_moc: got Error=1, want 0");
        end
        moc_prev = moc;
    end

    // mode 0: drop MFA after MOC; mode 1: one-cycle MFA pulse; mode 2: MFA held 10 cycles.
    task automatic op(input logic r, input logic [1:0] sz, input logic [8:0] a,
                      input logic [31:0] d, input int mode, input logic eerr,
                      input logic [31:0] edout, input string nm);
        exp_t e;
        int   lat;
        bit   seen;
        bit   held_ok;
        @(negedge clk);
        rw = r; size = sz; addr = a; din = d; mfa = 1'b1;
        e.err = eerr; e.dout = edout;
        sb.push_back(e);
        @(posedge clk); #1;
        // Scramble the bus during WAIT; the latched request must be used.
        addr = ~a; din = ~d; rw = ~r;
        if (mode == 1) mfa = 1'b0;
        check({nm, "_busy"}, {31'd0, busy}, 32'd1);
        lat = 0; seen = 0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (moc) seen = 1;
        end
        check({nm, "_latency"}, 32'(lat), 32'd3);
        if (mode == 2) begin
            held_ok = 1;
            repeat (6) begin
                @(posedge clk); #1;
                if (!moc || !busy) held_ok = 0;
            end
            check({nm, "_moc_held"}, {31'd0, held_ok}, 32'd1);
            mfa = 1'b0;
            @(posedge clk); #1;
            check({nm, "_moc_fall"}, {31'd0, moc}, 32'd0);
        end else if (mode == 1) begin
            @(posedge clk); #1;
            check({nm, "_pulse_width"}, {31'd0, moc}, 32'd0);
        end else begin
            mfa = 1'b0;
            @(posedge clk); #1;
            check({nm, "_moc_fall"}, {31'd0, moc}, 32'd0);
            check({nm, "_idle"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; mfa = 1'b0; rw = 1'b0; size = 2'b00; addr = 9'd0; din = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_moc",   {31'd0, moc},  32'd0);
        check("reset_busy",  {31'd0, busy}, 32'd0);
        check("reset_error", {31'd0, err},  32'd0);
        check("reset_dout",  dout,          32'd0);
        @(negedge clk);
        rst = 1'b0;

        //  rw    size   addr    data          mode err   expected DataOut
        op(1'b0, 2'b10, 9'h010, 32'hDEADBEEF, 0, 1'b0, 32'h00000000, "wr_w010");
        op(1'b1, 2'b00, 9'h010, 32'h0,        0, 1'b0, 32'h000000DE, "rd_b010");
        op(1'b1, 2'b01, 9'h012, 32'h0,        0, 1'b0, 32'h0000BEEF, "rd_h012");
        op(1'b1, 2'b00, 9'h013, 32'h0,        0, 1'b0, 32'h000000EF, "rd_b013");
        op(1'b0, 2'b01, 9'h010, 32'hFFFF1234, 0, 1'b0, 32'h000000EF, "wr_h010");
        op(1'b1, 2'b10, 9'h010, 32'h0,        0, 1'b0, 32'h1234BEEF, "rd_w010");
        op(1'b0, 2'b00, 9'h012, 32'hFFFFFF77, 0, 1'b0, 32'h1234BEEF, "wr_b012");
        op(1'b1, 2'b10, 9'h010, 32'h0,        0, 1'b0, 32'h123477EF, "rd_w010b");
        op(1'b1, 2'b10, 9'h011, 32'h0,        0, 1'b1, 32'h123477EF, "err_w011");
        op(1'b0, 2'b10, 9'h1FE, 32'hAAAAAAAA, 0, 1'b1, 32'h123477EF, "err_w1fe");
        op(1'b0, 2'b11, 9'h010, 32'h55555555, 0, 1'b1, 32'h123477EF, "err_size11");
        op(1'b1, 2'b01, 9'h1FF, 32'h0,        0, 1'b1, 32'h123477EF, "err_h1ff");
        op(1'b1, 2'b10, 9'h010, 32'h0,        0, 1'b0, 32'h123477EF, "rd_w010c");
        op(1'b0, 2'b10, 9'h1FC, 32'h01020304, 0, 1'b0, 32'h123477EF, "wr_w1fc");
        op(1'b1, 2'b00, 9'h1FF, 32'h0,        0, 1'b0, 32'h00000004, "rd_b1ff");
        op(1'b1, 2'b01, 9'h1FE, 32'h0,        0, 1'b0, 32'h00000304, "rd_h1fe");
        op(1'b0, 2'b10, 9'h020, 32'hCAFEF00D, 1, 1'b0, 32'h00000304, "wr_w020_pulse");

        // Write aborted by reset while in WAIT: no MOC, no memory change.
        @(negedge clk);
        rw = 1'b0; size = 2'b10; addr = 9'h020; din = 32'h11111111; mfa = 1'b1;
        @(posedge clk); #1;
        check("abort_busy_wait", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1; mfa = 1'b0;
        #1;
        check("abort_busy",  {31'd0, busy}, 32'd0);
        check("abort_moc",   {31'd0, moc},  32'd0);
        check("abort_error", {31'd0, err},  32'd0);
        check("abort_dout",  dout,          32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_moc", {31'd0, moc}, 32'd0);

        op(1'b1, 2'b10, 9'h020, 32'h0,        2, 1'b0, 32'hCAFEF00D, "rd_w020_held");

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
